// File: rtl/pipe_stage_reg_pkg.sv
// Shared choice-code definitions for the pipeline stage registers and the hazard detectors.
package pipe_ctrl_pkg;

    typedef logic [1:0] choice_t;

    localparam choice_t CHOICE_FLUSH = 2'b00;
    localparam choice_t CHOICE_LOAD  = 2'b01;
    localparam choice_t CHOICE_KEEP  = 2'b10;
    localparam choice_t CHOICE_RSVD  = 2'b11;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Payload channel across one pipeline stage boundary; master drives upstream data, slave is the stage.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    modport master (output in_data, output in_valid, input out_data, input out_valid);
    modport slave  (input in_data, input in_valid, output out_data, output out_valid);
endinterface

// File: rtl/pipe_stage_reg_choice_merge.sv
// Combinational fixed-priority merge of the three hazard choices: FLUSH beats KEEP beats LOAD.
module choice_merge
    import pipe_ctrl_pkg::*;
(
    input  choice_t lu_choice,
    input  choice_t j_choice,
    input  choice_t b_choice,
    output choice_t merged,
    output logic    rsvd_seen
);

    logic any_flush;
    logic any_keep;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        merged    = CHOICE_LOAD;
        rsvd_seen = (lu_choice == CHOICE_RSVD) || (j_choice == CHOICE_RSVD)
                 || (b_choice == CHOICE_RSVD);
        any_flush = (lu_choice == CHOICE_FLUSH) || (j_choice == CHOICE_FLUSH)
                 || (b_choice == CHOICE_FLUSH);
        // A reserved code is treated as KEEP so a corrupt request can only stall.
        any_keep  = (lu_choice == CHOICE_KEEP) || (j_choice == CHOICE_KEEP)
                 || (b_choice == CHOICE_KEEP) || rsvd_seen;

        if (any_flush) begin
            merged = CHOICE_FLUSH;
        end else if (any_keep) begin
            merged = CHOICE_KEEP;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with load/keep/flush control, stall tracking and sticky error flags.
// Optional PERF_CNT_EN adds saturating flush/keep event counters.
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
    parameter int unsigned      STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  choice_t          lu_choice,
    input  choice_t          j_choice,
    input  choice_t          b_choice,
    pipe_stage_reg_if.slave  stage,
    output logic [7:0]       stall_cnt,
    output logic             stall_timeout,
    output logic             choice_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]      flush_count,
    output logic [31:0]      keep_count
`endif
);

    localparam logic [7:0] STALL_LIMIT_C = 8'(STALL_LIMIT);

    choice_t          merged;
    logic             rsvd_seen;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;
    logic             stall_timeout_q, stall_timeout_d;
    logic             choice_err_q, choice_err_d;

    choice_merge u_merge (
        .lu_choice (lu_choice),
        .j_choice  (j_choice),
        .b_choice  (b_choice),
        .merged    (merged),
        .rsvd_seen (rsvd_seen)
    );

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        stall_cnt_d = 8'd0;
        case (merged)
            CHOICE_FLUSH: begin
                data_d  = FLUSH_VALUE;
                valid_d = 1'b0;
            end
            CHOICE_KEEP: begin
                stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
            end
            default: begin
                data_d  = stage.in_data;
                valid_d = stage.in_valid;
            end
        endcase
        stall_timeout_d = stall_timeout_q || (stall_cnt_d == STALL_LIMIT_C);
        choice_err_d    = choice_err_q || rsvd_seen;
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
        if (reset) begin
            data_q          <= FLUSH_VALUE;
            valid_q         <= 1'b0;
            stall_cnt_q     <= 8'd0;
            stall_timeout_q <= 1'b0;
            choice_err_q    <= 1'b0;
        end else begin
            data_q          <= data_d;
            valid_q         <= valid_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
            choice_err_q    <= choice_err_d;
        end
    end

    assign stage.out_data  = data_q;
    assign stage.out_valid = valid_q;
    assign stall_cnt       = stall_cnt_q;
    assign stall_timeout   = stall_timeout_q;
    assign choice_err      = choice_err_q;

`ifdef PERF_CNT_EN
    logic [31:0] flush_count_q, flush_count_d;
    logic [31:0] keep_count_q, keep_count_d;

    always_comb begin
        flush_count_d = flush_count_q;
        keep_count_d  = keep_count_q;
        if (merged == CHOICE_FLUSH && flush_count_q != 32'hFFFF_FFFF) begin
            flush_count_d = flush_count_q + 32'd1;
        end
        if (merged == CHOICE_KEEP && keep_count_q != 32'hFFFF_FFFF) begin
            keep_count_d = keep_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_count_q <= 32'd0;
            keep_count_q  <= 32'd0;
        end else begin
            flush_count_q <= flush_count_d;
            keep_count_q  <= keep_count_d;
        end
    end

    assign flush_count = flush_count_q;
    assign keep_count  = keep_count_q;
`endif

endmodule
